// File: rtl/iic_pkg.sv
// Shared definitions for the I2C target: FSM state encodings, the default
// device address and the meaning of the R/W bit in the address byte.
package iic_pkg;

   typedef enum logic [3:0] {
      IDLE      = 4'd0,
      DEV       = 4'd1,
      DEV_ACK   = 4'd2,
      WADDR     = 4'd3,
      WADDR_ACK = 4'd4,
      WDATA     = 4'd5,
      WDATA_ACK = 4'd6,
      RDATA     = 4'd7,
      RACK      = 4'd8,
      WAIT_STOP = 4'd9
   } iic_state_t;

   localparam logic [6:0] IIC_DEF_DEV_ADDR = 7'b1010101;

   localparam logic IIC_WRITE = 1'b0;
   localparam logic IIC_READ  = 1'b1;

endpackage

// File: rtl/iic_slave_module_if.sv
// Bus pins and local register-bank port of the I2C target, bundled so the
// master side (bench or peripheral) and the target share one definition.
interface iic_slave_module_if #(parameter int AW = 4);

   logic          SCL;
   logic          SDA_In;
   logic          SDA_Oe;
   logic [AW-1:0] Reg_Addr;
   logic [7:0]    Reg_Data;
   logic          Wr_Done;
   logic [AW-1:0] Wr_Addr;
   logic [3:0]    SQ_i;

   modport slave (
      input  SCL, SDA_In, Reg_Addr,
      output SDA_Oe, Reg_Data, Wr_Done, Wr_Addr, SQ_i
   );

   modport master (
      output SCL, SDA_In, Reg_Addr,
      input  SDA_Oe, Reg_Data, Wr_Done, Wr_Addr, SQ_i
   );

endinterface

// File: rtl/iic_bus_sync.sv
// Two-flop synchroniser for SCL/SDA with a delay flop for edge detection;
// all strobes are registered, so a pin change shows up as a strobe 3 CLK later.
module iic_bus_sync (
   input  logic CLK,
   input  logic RST,
   input  logic SCL,
   input  logic SDA_In,
   output logic scl_rise,
   output logic scl_fall,
   output logic start_det,
   output logic stop_det,
   output logic sda_bit
);

   logic scl_s1, scl_s2, scl_d;
   logic sda_s1, sda_s2, sda_d;

   // The bus idles high, so the chain resets to 1 to avoid a false edge after reset.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         scl_s1    <= 1'b1;
         scl_s2    <= 1'b1;
         scl_d     <= 1'b1;
         sda_s1    <= 1'b1;
         sda_s2    <= 1'b1;
         sda_d     <= 1'b1;
         scl_rise  <= 1'b0;
         scl_fall  <= 1'b0;
         start_det <= 1'b0;
         stop_det  <= 1'b0;
         sda_bit   <= 1'b1;
      end else begin
         scl_s1    <= SCL;
         scl_s2    <= scl_s1;
         scl_d     <= scl_s2;
         sda_s1    <= SDA_In;
         sda_s2    <= sda_s1;
         sda_d     <= sda_s2;
         scl_rise  <= scl_s2 & ~scl_d;
         scl_fall  <= ~scl_s2 & scl_d;
         start_det <= sda_d & ~sda_s2 & scl_s2;
         stop_det  <= ~sda_d & sda_s2 & scl_s2;
         sda_bit   <= sda_s2;
      end
   end

endmodule

// File: rtl/iic_slave_module.sv
// I2C target: address match, byte writes into a local bank with an
// auto-incrementing word pointer, and sequential reads back out over SDA.
module iic_slave_module
   import iic_pkg::*;
#(
   parameter logic [6:0] DEV_ADDR = IIC_DEF_DEV_ADDR,
   parameter int         AW       = 4
) (
   input  logic               CLK,
   input  logic               RST,
   iic_slave_module_if.slave  bus
);

   localparam int DEPTH = 2 ** AW;

   logic          scl_rise, scl_fall, start_det, stop_det, sda_bit;
   iic_state_t    state;
   logic [3:0]    bit_cnt;
   logic [7:0]    shift;
   logic          rw;
   logic [AW-1:0] ptr;
   logic [AW-1:0] ptr_inc;
   logic [7:0]    bank [DEPTH];
   logic          sda_oe;
   logic [7:0]    reg_data;
   logic          wr_done;
   logic [AW-1:0] wr_addr;
   logic [7:0]    next_byte;

   iic_bus_sync u_sync (
      .CLK       (CLK),
      .RST       (RST),
      .SCL       (bus.SCL),
      .SDA_In    (bus.SDA_In),
      .scl_rise  (scl_rise),
      .scl_fall  (scl_fall),
      .start_det (start_det),
      .stop_det  (stop_det),
      .sda_bit   (sda_bit)
   );

   assign next_byte = {shift[6:0], sda_bit};
   assign ptr_inc   = ptr + 1'b1;

   // Protocol FSM; bank writes live here too so the whole bank clears on reset.
   // In the ACK states bit_cnt flags whether the ACK low is already being driven.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state   <= IDLE;
         bit_cnt <= '0;
         shift   <= '0;
         rw      <= IIC_WRITE;
         ptr     <= '0;
         sda_oe  <= 1'b0;
         wr_done <= 1'b0;
         wr_addr <= '0;
         for (int i = 0; i < DEPTH; i++) bank[i] <= '0;
      end else begin
         wr_done <= 1'b0;
         if (stop_det) begin
            state   <= IDLE;
            sda_oe  <= 1'b0;
            bit_cnt <= '0;
         end else if (start_det) begin
            state   <= DEV;
            sda_oe  <= 1'b0;
            bit_cnt <= '0;
         end else begin
            case (state)
               DEV: if (scl_rise) begin
                  shift   <= next_byte;
                  bit_cnt <= bit_cnt + 4'd1;
                  if (bit_cnt == 4'd7) begin
                     bit_cnt <= '0;
                     if (next_byte[7:1] == DEV_ADDR) begin
                        rw    <= next_byte[0];
                        state <= DEV_ACK;
                     end else begin
                        state <= WAIT_STOP;
                     end
                  end
               end
               DEV_ACK, WADDR_ACK, WDATA_ACK: if (scl_fall) begin
                  if (bit_cnt == 4'd0) begin
                     sda_oe  <= 1'b1;
                     bit_cnt <= 4'd1;
                  end else begin
                     sda_oe  <= 1'b0;
                     bit_cnt <= '0;
                     if (state == DEV_ACK && rw == IIC_READ) begin
                        sda_oe  <= ~bank[ptr][7];
                        shift   <= {bank[ptr][6:0], 1'b0};
                        bit_cnt <= 4'd1;
                        state   <= RDATA;
                     end else if (state == DEV_ACK) begin
                        state <= WADDR;
                     end else begin
                        state <= WDATA;
                     end
                  end
               end
               WADDR: if (scl_rise) begin
                  shift   <= next_byte;
                  bit_cnt <= bit_cnt + 4'd1;
                  if (bit_cnt == 4'd7) begin
                     ptr     <= next_byte[AW-1:0];
                     bit_cnt <= '0;
                     state   <= WADDR_ACK;
                  end
               end
               WDATA: if (scl_rise) begin
                  shift   <= next_byte;
                  bit_cnt <= bit_cnt + 4'd1;
                  if (bit_cnt == 4'd7) begin
                     bank[ptr] <= next_byte;
                     wr_done   <= 1'b1;
                     wr_addr   <= ptr;
                     ptr       <= ptr_inc;
                     bit_cnt   <= '0;
                     state     <= WDATA_ACK;
                  end
               end
               RDATA: if (scl_fall) begin
                  if (bit_cnt == 4'd8) begin
                     sda_oe  <= 1'b0;
                     bit_cnt <= '0;
                     state   <= RACK;
                  end else begin
                     sda_oe  <= ~shift[7];
                     shift   <= {shift[6:0], 1'b0};
                     bit_cnt <= bit_cnt + 4'd1;
                  end
               end
               RACK: if (scl_rise) begin
                  if (!sda_bit) begin
                     ptr     <= ptr_inc;
                     shift   <= bank[ptr_inc];
                     bit_cnt <= '0;
                     state   <= RDATA;
                  end else begin
                     state <= WAIT_STOP;
                  end
               end
               WAIT_STOP: sda_oe <= 1'b0;
               default: state <= state;
            endcase
         end
      end
   end

   // Local read port: a same-cycle commit to the same index returns the old byte.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) reg_data <= '0;
      else     reg_data <= bank[bus.Reg_Addr];
   end

   assign bus.SDA_Oe   = sda_oe;
   assign bus.Reg_Data = reg_data;
   assign bus.Wr_Done  = wr_done;
   assign bus.Wr_Addr  = wr_addr;
   assign bus.SQ_i     = state;

endmodule

// File: tb/tb_iic_slave_module.sv
// Bit-banged I2C master driving iic_slave_module, with scoreboard queues for
// expected write commits and expected read-back bytes.
`timescale 1ns/1ps
module tb_iic_slave_module;
   import iic_pkg::*;

   localparam int PH = 10;

   logic CLK = 1'b0;
   logic RST = 1'b1;
   logic sdaM = 1'b1;
   logic oeWatch = 1'b0;
   logic oeSeen = 1'b0;
   int   checkCount = 0;
   int   errorCount = 0;
   logic [3:0] expWrQ [$];
   logic [7:0] expRdQ [$];

   iic_slave_module_if #(.AW(4)) bus ();

   iic_slave_module #(.DEV_ADDR(7'b1010101), .AW(4)) dut (
      .CLK (CLK),
      .RST (RST),
      .bus (bus)
   );

   // Open-drain wired-AND of the master's release and the target's pull-down.
   assign bus.SDA_In = sdaM & ~bus.SDA_Oe;

   always #25 CLK = ~CLK;

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checkCount++;
      if (actual !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
      end
   endtask

   task automatic waitClk(input int n);
      repeat (n) @(negedge CLK);
   endtask

   // Every commit pulse must match the next expected bank index.
   always @(negedge CLK) begin
      if (bus.Wr_Done) begin
         if (expWrQ.size() == 0) checkOutput("wrDoneUnexpected", 32'd1, 32'd0);
         else checkOutput("wrAddr", {28'd0, bus.Wr_Addr}, {28'd0, expWrQ.pop_front()});
      end
      if (oeWatch && bus.SDA_Oe) oeSeen = 1'b1;
   end

   task automatic clockBit(input logic b, output logic r);
      waitClk(2);
      sdaM = b;
      waitClk(PH);
      bus.SCL = 1'b1;
      waitClk(PH / 2);
      r = bus.SDA_In;
      waitClk(PH / 2);
      bus.SCL = 1'b0;
   endtask

   task automatic startCond();
      waitClk(2);
      sdaM = 1'b1;
      waitClk(PH);
      bus.SCL = 1'b1;
      waitClk(PH);
      sdaM = 1'b0;
      waitClk(PH);
      bus.SCL = 1'b0;
   endtask

   task automatic stopCond();
      waitClk(2);
      sdaM = 1'b0;
      waitClk(PH);
      bus.SCL = 1'b1;
      waitClk(PH);
      sdaM = 1'b1;
      waitClk(PH);
   endtask

   task automatic sendByte(input logic [7:0] d, output logic ack);
      logic r;
      for (int i = 7; i >= 0; i--) clockBit(d[i], r);
      clockBit(1'b1, ack);
   endtask

   task automatic readByte(input logic nack, output logic [7:0] d);
      logic r;
      for (int i = 7; i >= 0; i--) begin
         clockBit(1'b1, r);
         d[i] = r;
      end
      clockBit(nack, r);
   endtask

   // Full write transaction: address, word pointer, then n data bytes, STOP.
   task automatic applyStimulus(input logic [7:0] word, input logic [7:0] d0, input logic [7:0] d1, input int n);
      logic ack;
      startCond();
      sendByte(8'hAA, ack);
      checkOutput("ackAddrW", {31'd0, ack}, 32'd0);
      sendByte(word, ack);
      checkOutput("ackWord", {31'd0, ack}, 32'd0);
      for (int k = 0; k < n; k++) begin
         expWrQ.push_back(word[3:0] + 4'(k));
         sendByte((k == 0) ? d0 : d1, ack);
         checkOutput("ackData", {31'd0, ack}, 32'd0);
      end
      stopCond();
   endtask

   task automatic readBank(input logic [3:0] a, input logic [7:0] expected, input string tag);
      bus.Reg_Addr = a;
      waitClk(2);
      checkOutput(tag, {24'd0, bus.Reg_Data}, {24'd0, expected});
   endtask

   initial begin
      logic ack;
      logic r;
      logic [7:0] d;
      bus.SCL = 1'b1;
      bus.Reg_Addr = '0;
      waitClk(3);
      checkOutput("rstOe", {31'd0, bus.SDA_Oe}, 32'd0);
      checkOutput("rstData", {24'd0, bus.Reg_Data}, 32'd0);
      checkOutput("rstWrDone", {31'd0, bus.Wr_Done}, 32'd0);
      checkOutput("rstWrAddr", {28'd0, bus.Wr_Addr}, 32'd0);
      checkOutput("rstState", {28'd0, bus.SQ_i}, {28'd0, IDLE});
      RST = 1'b0;
      waitClk(5);

      $display("[TB] basic write");
      applyStimulus(8'hAA, 8'hAA, 8'h00, 1);
      checkOutput("writeIdle", {28'd0, bus.SQ_i}, {28'd0, IDLE});
      readBank(4'hA, 8'hAA, "bankA");

      $display("[TB] read with repeated START");
      applyStimulus(8'h03, 8'h5C, 8'h81, 2);
      readBank(4'h4, 8'h81, "bank4");
      startCond();
      sendByte(8'hAA, ack);
      checkOutput("ackRdAddrW", {31'd0, ack}, 32'd0);
      sendByte(8'h03, ack);
      checkOutput("ackRdWord", {31'd0, ack}, 32'd0);
      startCond();
      sendByte(8'hAB, ack);
      checkOutput("ackAddrR", {31'd0, ack}, 32'd0);
      expRdQ.push_back(8'h5C);
      expRdQ.push_back(8'h81);
      readByte(1'b0, d);
      checkOutput("readByte0", {24'd0, d}, {24'd0, expRdQ.pop_front()});
      readByte(1'b1, d);
      checkOutput("readByte1", {24'd0, d}, {24'd0, expRdQ.pop_front()});
      waitClk(6);
      checkOutput("nackRelease", {31'd0, bus.SDA_Oe}, 32'd0);
      checkOutput("nackState", {28'd0, bus.SQ_i}, {28'd0, WAIT_STOP});
      stopCond();

      $display("[TB] wrong device address");
      oeWatch = 1'b1;
      startCond();
      sendByte(8'hA0, ack);
      checkOutput("wrongAddrNack", {31'd0, ack}, 32'd1);
      checkOutput("wrongAddrState", {28'd0, bus.SQ_i}, {28'd0, WAIT_STOP});
      sendByte(8'h55, ack);
      checkOutput("wrongAddrHold", {28'd0, bus.SQ_i}, {28'd0, WAIT_STOP});
      stopCond();
      oeWatch = 1'b0;
      checkOutput("wrongAddrOe", {31'd0, oeSeen}, 32'd0);
      checkOutput("wrongAddrIdle", {28'd0, bus.SQ_i}, {28'd0, IDLE});

      $display("[TB] pointer wrap");
      applyStimulus(8'h0F, 8'h11, 8'h22, 2);
      readBank(4'hF, 8'h11, "bankF");
      readBank(4'h0, 8'h22, "bank0");

      $display("[TB] abort mid-byte");
      startCond();
      sendByte(8'hAA, ack);
      sendByte(8'h05, ack);
      for (int i = 0; i < 5; i++) clockBit(1'b1, r);
      stopCond();
      checkOutput("abortIdle", {28'd0, bus.SQ_i}, {28'd0, IDLE});
      readBank(4'h5, 8'h00, "abortNoCommit");
      applyStimulus(8'h02, 8'h3C, 8'h00, 1);
      readBank(4'h2, 8'h3C, "bank2");

      $display("[TB] reset mid-read");
      bus.Reg_Addr = 4'h3;
      startCond();
      sendByte(8'hAA, ack);
      sendByte(8'h03, ack);
      startCond();
      sendByte(8'hAB, ack);
      waitClk(6);
      checkOutput("readDriving", {31'd0, bus.SDA_Oe}, 32'd1);
      RST = 1'b1;
      #1;
      checkOutput("rstAsyncOe", {31'd0, bus.SDA_Oe}, 32'd0);
      checkOutput("rstMidState", {28'd0, bus.SQ_i}, {28'd0, IDLE});
      checkOutput("rstMidWrAddr", {28'd0, bus.Wr_Addr}, 32'd0);
      checkOutput("rstMidWrDone", {31'd0, bus.Wr_Done}, 32'd0);
      waitClk(1);
      RST = 1'b0;
      waitClk(2);
      checkOutput("rstBankClear", {24'd0, bus.Reg_Data}, 32'd0);
      bus.SCL = 1'b1;
      sdaM = 1'b1;
      waitClk(PH);
      checkOutput("rstFinalState", {28'd0, bus.SQ_i}, {28'd0, IDLE});

      checkOutput("wrQueueEmpty", expWrQ.size(), 32'd0);
      checkOutput("rdQueueEmpty", expRdQ.size(), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end

   initial begin
      #(50 * 100000);
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
